// File: rtl/sram_pattern_tester.sv
`default_nettype none
// ============================================================================
// Module   : sram_pattern_tester
// Purpose  : Self-running whole-array test master for the sram_ctrl2 request
//            side. On start it writes P(a) = a[7:0] ^ a[15:8] ^ SEED to every
//            address 0..LAST_ADDR, reads every location back, compares it and
//            reports pass/fail, a saturating error count and the first
//            failing address/data.
// Option   : `define SRAM_TESTER_INVERT_PASS_EN adds a second write+read sweep
//            using ~P(a); errors from both sweeps accumulate.
// Ports    : clk, reset (sync, active high), start (sampled in IDLE only)
//            busy, done (1-cycle pulse), pass, err_count, first_err_addr,
//            first_err_data                          - result/status outputs
//            rw (1=read), addr, data_f2s, data_s2f_r - sram_ctrl2 request side
// Revision : 1.0 - initial release
// ============================================================================
module sram_pattern_tester #(
  parameter int                ADDR_W        = 21,
  parameter int                DATA_W        = 8,
  parameter logic [ADDR_W-1:0] LAST_ADDR     = 21'h1FFFFF,
  parameter int                ACCESS_CYCLES = 4,
  parameter logic [7:0]        SEED          = 8'hA5,
  parameter int                ERR_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  output logic              rw,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_f2s,
  input  logic [DATA_W-1:0] data_s2f_r
);

  localparam int               c_HOLD_W    = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic [c_HOLD_W-1:0] r_hold;       // position inside the current access hold
  logic                r_inv;        // 1 while running the inverted sweep
  logic                r_first_seen; // a mismatch has already been latched

  // Zero-extend so the upper pattern byte is defined for any address width.
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a, input logic inv);
    logic [ADDR_W+15:0] ext;
    logic [7:0]         p;
    ext = {16'd0, a};
    p   = ext[7:0] ^ ext[15:8] ^ SEED;
    return DATA_W'(p) ^ {DATA_W{inv}};
  endfunction

  logic              w_hold_last;
  logic              w_at_last;
  logic              w_final_sweep;
  logic [ADDR_W-1:0] w_addr_next;
  logic              w_mismatch;
  logic [ERR_W-1:0]  w_err_next;

  assign w_hold_last = (r_hold == c_HOLD_LAST);
  // Equality terminate, so LAST_ADDR = all-ones never needs a wrapped counter.
  assign w_at_last   = (addr == LAST_ADDR);
  assign w_addr_next = addr + ADDR_W'(1);
  assign w_mismatch  = (data_s2f_r != pattern(addr, r_inv));
  assign w_err_next  = (w_mismatch && !(&err_count)) ? err_count + ERR_W'(1) : err_count;

`ifdef SRAM_TESTER_INVERT_PASS_EN
  assign w_final_sweep = r_inv;
`else
  assign w_final_sweep = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_hold         <= '0;
      r_inv          <= 1'b0;
      r_first_seen   <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      rw             <= 1'b1;
      addr           <= '0;
      data_f2s       <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state        <= S_WRITE;
            r_hold         <= '0;
            r_inv          <= 1'b0;
            r_first_seen   <= 1'b0;
            busy           <= 1'b1;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            rw             <= 1'b0;
            addr           <= '0;
            data_f2s       <= pattern('0, 1'b0);
          end
        end

        S_WRITE: begin
          r_hold <= w_hold_last ? '0 : r_hold + c_HOLD_W'(1);
          if (w_hold_last) begin
            if (w_at_last) begin
              r_state <= S_READ;
              rw      <= 1'b1;
              addr    <= '0;
            end else begin
              addr     <= w_addr_next;
              data_f2s <= pattern(w_addr_next, r_inv);
            end
          end
        end

        S_READ: begin
          r_hold <= w_hold_last ? '0 : r_hold + c_HOLD_W'(1);
          // Sample on the last hold cycle: gives the controller
          // ACCESS_CYCLES-1 clocks of read latency.
          if (w_hold_last) begin
            err_count <= w_err_next;
            if (w_mismatch && !r_first_seen) begin
              r_first_seen   <= 1'b1;
              first_err_addr <= addr;
              first_err_data <= data_s2f_r;
            end
            if (w_at_last && w_final_sweep) begin
              r_state <= S_DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
              rw      <= 1'b1;
              // Uses the next count so a mismatch on the final sample counts.
              pass    <= (w_err_next == '0);
            end else if (w_at_last) begin
              r_state  <= S_WRITE;
              r_inv    <= 1'b1;
              rw       <= 1'b0;
              addr     <= '0;
              data_f2s <= pattern('0, 1'b1);
            end else begin
              addr <= w_addr_next;
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/sram_pattern_tester.md
# sram_pattern_tester

Self-running SRAM pattern tester that drives the request side of `sram_ctrl2` (`rw`, `addr`, `data_f2s`, `data_s2f_r`) as an alternative master to `checker`. On a start pulse it writes a deterministic address-derived pattern to every location from 0 to `LAST_ADDR`, then reads each one back and compares it. It reports pass/fail, a saturating error count, and the first failing address and data. It gives a quick whole-array check of the SDRAM-backed SRAM wrapper without UART traffic.

## Interface
Parameters:
- `ADDR_W`, 21: address width; matches `sram_ctrl2` `addr`.
- `DATA_W`, 8: data width.
- `LAST_ADDR`, 21'h1FFFFF: highest tested address. The range is always 0..`LAST_ADDR`.
- `ACCESS_CYCLES`, 4: clocks each access is held stable. Legal values are ≥ 2.
- `SEED`, 8'hA5: pattern XOR seed.
- `ERR_W`, 16: error counter width.

Ports:
- `clk`, in, 1: system clock (PLL `c0`).
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begin a test. Sampled only in IDLE.
- `busy`, out, 1: test in progress.
- `done`, out, 1: one-cycle pulse when a test completes.
- `pass`, out, 1: 1 when the last completed test had zero errors. Held until the next start.
- `err_count`, out, `ERR_W`: number of mismatches. Saturates at all-ones.
- `first_err_addr`, out, `ADDR_W`: address of the first mismatch.
- `first_err_data`, out, `DATA_W`: data read at the first mismatch.
- `rw`, out, 1: to `sram_ctrl2`. 1 = read, 0 = write.
- `addr`, out, `ADDR_W`: to `sram_ctrl2`.
- `data_f2s`, out, `DATA_W`: write data to `sram_ctrl2`.
- `data_s2f_r`, in, `DATA_W`: read data from `sram_ctrl2`.

## Operation
- Pattern: P(a) = a[7:0] ^ a[15:8] ^ `SEED`.
- States:
  - IDLE: `start`=1 → WRITE. On entry to WRITE, clear `err_count`, `pass`, `first_err_*`, set `addr`=0, `rw`=0, `data_f2s`=P(0).
  - WRITE: hold each access for `ACCESS_CYCLES` clocks, then advance `addr`. After `LAST_ADDR` completes → READ with `addr`=0, `rw`=1.
  - READ: hold each access for `ACCESS_CYCLES` clocks. On the last hold cycle, sample `data_s2f_r` and compare it with P(`addr`).
    - On mismatch, increment `err_count` (saturating).
    - If this is the first mismatch, latch `first_err_addr`/`first_err_data`.
    - After `LAST_ADDR` → DONE.
  - DONE: one cycle. `done`=1, `busy`=0, `pass`=(`err_count`==0, including any mismatch sampled in the final cycle), `rw`=1 → IDLE.
- `rw`, `addr` and `data_f2s` change only at access boundaries and are stable for the whole hold.
- Outside WRITE, `rw`=1; a write never occurs outside WRITE.
- `start` while busy is ignored.
- The address counter is `ADDR_W` wide. There is no wrap: termination is by an equality compare with `LAST_ADDR`, so `LAST_ADDR`=all-ones is legal.
- `reset` mid-test aborts immediately: the next cycle is IDLE with reset values and no further writes. There is no partial `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_addr`=0, `first_err_data`=0, `rw`=1, `addr`=0, `data_f2s`=0.
- `start` sampled high in cycle t → `busy`=1 and the first write is driven in cycle t+1.
- With N=`LAST_ADDR`+1 and K passes (1, or 2 with the macro): `done`=1 in cycle t+1+2·N·`ACCESS_CYCLES`·K.
- The read sample point is the `ACCESS_CYCLES`-th cycle of the hold. This gives `sram_ctrl2` `ACCESS_CYCLES`−1 clocks of read latency.
- Result outputs update in the cycle after each sample. Final values are valid in the `done` cycle.

## Configuration
- `SRAM_TESTER_INVERT_PASS_EN`:
  - Defined: after the first READ phase, run a second WRITE+READ sweep using ~P(a). Errors from both sweeps accumulate, and `first_err_*` keeps the earliest. `done` comes after both sweeps.
  - Undefined: single sweep only.

## Test plan
Use a behavioural SRAM model with 1-cycle read latency, `LAST_ADDR`=15, `ACCESS_CYCLES`=4, `SEED`=8'hA5.
1. Clean memory; `start` at cycle t → `done` at t+129, `pass`=1, `err_count`=0. Model contents: addr 0 = 8'hA5, addr 5 = 8'hA0.
2. Model forces bit 5 low at addr 5 → `err_count`=1, `first_err_addr`=5, `first_err_data`=8'h80, `pass`=0.
3. `ERR_W`=4; model returns 8'h00 for every read → `err_count`=4'hF (saturated), `first_err_addr`=0, `first_err_data`=8'h00.
4. `start` re-pulsed at t+20; then `reset` at t+40 → the extra start has no effect. The cycle after reset shows all outputs at reset values, `rw`=1, no model writes after t+40, and no `done`.
5. With `SRAM_TESTER_INVERT_PASS_EN` defined, clean memory → `done` at t+257, addr 0 holds 8'h5A, `pass`=1.
